// File: rtl/sram_pipe.sv
// sram_pipe: single-port SRAM wrapper built from 64-bit cuts, read latency 1 or 2 (OUT_REGS).
// Define SRAM_PIPE_INIT_SCRUB_EN to zero the whole array after every reset before granting requests.
module sram_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int USER_EN    = 0,
    parameter int NUM_WORDS  = 1024,
    parameter int OUT_REGS   = 0,
    parameter     SIM_INIT   = "none"
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [$clog2(NUM_WORDS)-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [(DATA_WIDTH+7)/8-1:0]   be_i,
    input  logic [USER_WIDTH-1:0]         wuser_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [USER_WIDTH-1:0]         ruser_o,
    output logic                          busy_o
);
    localparam int AW   = $clog2(NUM_WORDS);
    localparam int NCUT = (DATA_WIDTH + 63) / 64;
    localparam int PW   = NCUT * 64;
    localparam int PBE  = NCUT * 8;

    logic                  busy, scrubbing, acc;
    logic [AW-1:0]         scrub_addr;
    logic                  mem_we, mem_re;
    logic [AW-1:0]         mem_addr;
    logic [PW-1:0]         mem_wdata, cut_rd;
    logic [PBE-1:0]        mem_be;
    logic [USER_WIDTH-1:0] mem_wuser, urd;
    logic [OUT_REGS:0]     vld_q;

    // SIM_INIT only steers simulation models of the physical cuts.
    logic unused_sim_init;
    assign unused_sim_init = (SIM_INIT == "none");

`ifdef SRAM_PIPE_INIT_SCRUB_EN
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCRUB = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] scrub_addr_q, scrub_addr_d;

    always_comb begin
        state_d      = state_q;
        scrub_addr_d = scrub_addr_q;
        case (state_q)
            S_IDLE:  state_d = S_SCRUB;
            S_SCRUB: begin
                if (scrub_addr_q == AW'(NUM_WORDS - 1)) state_d = S_DONE;
                else scrub_addr_d = scrub_addr_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            scrub_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            scrub_addr_q <= scrub_addr_d;
        end
    end

    assign busy       = (state_q != S_DONE);
    assign scrubbing  = (state_q == S_SCRUB);
    assign scrub_addr = scrub_addr_q;
`else
    assign busy       = 1'b0;
    assign scrubbing  = 1'b0;
    assign scrub_addr = '0;
`endif

    assign gnt_o  = ~busy;
    assign busy_o = busy;
    assign acc    = req_i & gnt_o;

    // The scrub engine owns the port while busy; requests are never granted then.
    assign mem_we    = scrubbing | (acc & we_i);
    assign mem_re    = acc & ~we_i;
    assign mem_addr  = scrubbing ? scrub_addr : addr_i;
    assign mem_wdata = scrubbing ? '0 : PW'(wdata_i);
    assign mem_be    = scrubbing ? '1 : PBE'(be_i);
    assign mem_wuser = scrubbing ? '0 : wuser_i;

    for (genvar c = 0; c < NCUT; c++) begin : g_cut
        logic [63:0] mem [NUM_WORDS];
        logic [63:0] rd_q;

        always_ff @(posedge clk_i) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_be[c*8+b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[c*64+b*8 +: 8];
                end
            end
        end

        // Read register only loads on a read, so data holds between rvalid pulses.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)       rd_q <= '0;
            else if (mem_re) rd_q <= mem[mem_addr];
        end

        assign cut_rd[c*64 +: 64] = rd_q;
    end

    if (PW > DATA_WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^cut_rd[PW-1:DATA_WIDTH];
    end

    if (USER_EN != 0) begin : g_user
        logic [USER_WIDTH-1:0] umem [NUM_WORDS];
        logic [USER_WIDTH-1:0] urd_q;

        always_ff @(posedge clk_i) begin
            if (mem_we && |mem_be) umem[mem_addr] <= mem_wuser;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)       urd_q <= '0;
            else if (mem_re) urd_q <= umem[mem_addr];
        end

        assign urd = urd_q;
    end else begin : g_nouser
        logic unused_user;
        assign unused_user = ^mem_wuser;
        assign urd         = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= mem_re;
            for (int i = 1; i <= OUT_REGS; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    assign rvalid_o = vld_q[OUT_REGS];

    if (OUT_REGS != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] out_q;
        logic [USER_WIDTH-1:0] uout_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                out_q  <= '0;
                uout_q <= '0;
            end else if (vld_q[0]) begin
                out_q  <= cut_rd[DATA_WIDTH-1:0];
                uout_q <= urd;
            end
        end

        assign rdata_o = out_q;
        assign ruser_o = uout_q;
    end else begin : g_noreg
        assign rdata_o = cut_rd[DATA_WIDTH-1:0];
        assign ruser_o = urd;
    end
endmodule

// File: tb/tb_sram_pipe.sv
// Directed bench for sram_pipe: a 64-bit latency-1 instance and a 72-bit latency-2 user-enabled
// instance share stimulus; scrub checks run when SRAM_PIPE_INIT_SCRUB_EN is defined.
module tb_sram_pipe;
`ifdef SRAM_PIPE_INIT_SCRUB_EN
    localparam logic SCRUB = 1'b1;
`else
    localparam logic SCRUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req, we;
    logic [3:0]  addr, wuser;
    logic [71:0] wdata;
    logic [8:0]  be;

    logic        gnt_a, rv_a, busy_a, gnt_b, rv_b, busy_b;
    logic [63:0] rdata_a;
    logic [71:0] rdata_b;
    logic [3:0]  ruser_a, ruser_b;

    int total = 0;
    int bad   = 0;

    sram_pipe #(.DATA_WIDTH(64), .USER_WIDTH(4), .USER_EN(0), .NUM_WORDS(16), .OUT_REGS(0)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata[63:0]), .be_i(be[7:0]), .wuser_i(wuser),
        .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rdata_a), .ruser_o(ruser_a), .busy_o(busy_a));

    sram_pipe #(.DATA_WIDTH(72), .USER_WIDTH(4), .USER_EN(1), .NUM_WORDS(16), .OUT_REGS(1)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .wuser_i(wuser),
        .gnt_o(gnt_b), .rvalid_o(rv_b), .rdata_o(rdata_b), .ruser_o(ruser_b), .busy_o(busy_b));

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [71:0] wdata;
        logic [8:0]  be;
        logic [3:0]  wuser;
        logic [71:0] exp;
        logic [3:0]  uexp;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; wuser = '0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((busy_a || busy_b) && n < 100) begin
            tick();
            n++;
        end
        chk("ready_timeout", 72'(n >= 100), 72'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [71:0] d, input logic [8:0] b, input logic [3:0] u);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b; wuser = u;
        tick();
        idle();
    endtask

    // Read one word; A answers one cycle after acceptance, B two cycles after.
    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [71:0] exp, input logic [3:0] uexp);
        logic [63:0] hold_a;
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        idle();
        chk({nm, " rv_a"}, 72'(rv_a), 72'd1);
        chk({nm, " rdata_a"}, 72'(rdata_a), 72'(exp[63:0]));
        chk({nm, " ruser_a"}, 72'(ruser_a), 72'd0);
        chk({nm, " rv_b early"}, 72'(rv_b), 72'd0);
        hold_a = rdata_a;
        tick();
        chk({nm, " rv_a pulse"}, 72'(rv_a), 72'd0);
        chk({nm, " rdata_a hold"}, 72'(rdata_a), 72'(hold_a));
        chk({nm, " rv_b"}, 72'(rv_b), 72'd1);
        chk({nm, " rdata_b"}, rdata_b, exp);
        chk({nm, " ruser_b"}, 72'(ruser_b), 72'(uexp));
    endtask

    initial begin
        int n;
        logic any_rv;

        tbl[0]  = '{1'b1, 4'd5, 72'h00_DEADBEEF_CAFEF00D, 9'h1FF, 4'h3, 72'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'd5, 72'h0, 9'h0, 4'h0, 72'h00_DEADBEEF_CAFEF00D, 4'h3};
        tbl[2]  = '{1'b1, 4'd2, 72'hFF_FFFFFFFF_FFFFFFFF, 9'h1FF, 4'hF, 72'h0, 4'h0};
        tbl[3]  = '{1'b1, 4'd2, 72'h00_00000000_00000000, 9'h100, 4'h0, 72'h0, 4'h0};
        tbl[4]  = '{1'b0, 4'd2, 72'h0, 9'h0, 4'h0, 72'h00_FFFFFFFF_FFFFFFFF, 4'h0};
        tbl[5]  = '{1'b1, 4'd3, 72'h11_22334455_66778899, 9'h1FF, 4'h5, 72'h0, 4'h0};
        tbl[6]  = '{1'b1, 4'd3, 72'hAA_BBCCDDEE_FF001122, 9'h0A5, 4'hA, 72'h0, 4'h0};
        tbl[7]  = '{1'b0, 4'd3, 72'h0, 9'h0, 4'h0, 72'h11_BB33DD55_66008822, 4'hA};
        tbl[8]  = '{1'b1, 4'd1, 72'h0F_01234567_89ABCDEF, 9'h1FF, 4'h6, 72'h0, 4'h0};
        tbl[9]  = '{1'b1, 4'd1, 72'h01_00000000_00000001, 9'h000, 4'h7, 72'h0, 4'h0};
        tbl[10] = '{1'b0, 4'd1, 72'h0, 9'h0, 4'h0, 72'h0F_01234567_89ABCDEF, 4'h6};
        tbl[11] = '{1'b1, 4'd4, 72'h00_00000000_00000000, 9'h1FF, 4'h0, 72'h0, 4'h0};
        tbl[12] = '{1'b1, 4'd4, 72'h55_00000000_0000005A, 9'h001, 4'hA, 72'h0, 4'h0};
        tbl[13] = '{1'b0, 4'd4, 72'h0, 9'h0, 4'h0, 72'h00_00000000_0000005A, 4'hA};

        // Reset state
        idle();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst rv_a", 72'(rv_a), 72'd0);
        chk("rst rv_b", 72'(rv_b), 72'd0);
        chk("rst rdata_a", 72'(rdata_a), 72'd0);
        chk("rst rdata_b", rdata_b, 72'd0);
        chk("rst ruser_b", 72'(ruser_b), 72'd0);
        chk("rst busy_b", 72'(busy_b), 72'(SCRUB));
        chk("rst gnt_b", 72'(gnt_b), 72'(!SCRUB));
        rst = 1'b0;

`ifdef SRAM_PIPE_INIT_SCRUB_EN
        // busy must last IDLE + 16 scrub cycles while requests are ignored
        n = 0;
        any_rv = 1'b0;
        req = 1'b1; we = 1'b0; addr = 4'd0;
        while (busy_b && n < 100) begin
            tick();
            n++;
            any_rv |= rv_a | rv_b;
        end
        idle();
        chk("scrub busy cycles", 72'(n), 72'd17);
        chk("scrub busy_a", 72'(busy_a), 72'd0);
        chk("scrub gnt_b", 72'(gnt_b), 72'd1);
        repeat (2) begin
            tick();
            any_rv |= rv_a | rv_b;
        end
        chk("scrub req ignored", 72'(any_rv), 72'd0);
        rd_chk("scrub rd15", 4'd15, 72'd0, 4'h0);
`else
        tick();
        chk("noscrub busy_a", 72'(busy_a), 72'd0);
        chk("noscrub gnt_a", 72'(gnt_a), 72'd1);
`endif
        wait_ready();

        // Table-driven single accesses
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].we) begin
                wr(tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].wuser);
                chk($sformatf("v%0d wr rv_a", i), 72'(rv_a), 72'd0);
                tick();
                chk($sformatf("v%0d wr rv_b", i), 72'(rv_b), 72'd0);
            end else begin
                rd_chk($sformatf("v%0d", i), tbl[i].addr, tbl[i].exp, tbl[i].uexp);
            end
        end

        // Back-to-back reads @1,@2,@3: in order, no bubbles
        req = 1'b1; we = 1'b0; addr = 4'd1;
        tick();
        chk("b2b0 rv_a", 72'(rv_a), 72'd1);
        chk("b2b0 rdata_a", 72'(rdata_a), 72'(tbl[10].exp[63:0]));
        chk("b2b0 rv_b", 72'(rv_b), 72'd0);
        addr = 4'd2;
        tick();
        chk("b2b1 rv_a", 72'(rv_a), 72'd1);
        chk("b2b1 rdata_a", 72'(rdata_a), 72'(tbl[4].exp[63:0]));
        chk("b2b1 rv_b", 72'(rv_b), 72'd1);
        chk("b2b1 rdata_b", rdata_b, tbl[10].exp);
        addr = 4'd3;
        tick();
        chk("b2b2 rdata_a", 72'(rdata_a), 72'(tbl[7].exp[63:0]));
        chk("b2b2 rv_b", 72'(rv_b), 72'd1);
        chk("b2b2 rdata_b", rdata_b, tbl[4].exp);
        idle();
        tick();
        chk("b2b3 rv_a", 72'(rv_a), 72'd0);
        chk("b2b3 rv_b", 72'(rv_b), 72'd1);
        chk("b2b3 rdata_b", rdata_b, tbl[7].exp);
        chk("b2b3 ruser_b", 72'(ruser_b), 72'(tbl[7].uexp));
        tick();
        chk("b2b4 rv_b", 72'(rv_b), 72'd0);
        chk("b2b4 rdata_b hold", rdata_b, tbl[7].exp);

        // Read the cycle right after a write to the same address
        wr(4'd6, 72'h3C_00112233_44556677, 9'h1FF, 4'h9);
        rd_chk("raw", 4'd6, 72'h3C_00112233_44556677, 4'h9);

        // Reset with a read in flight in the latency-2 instance
        req = 1'b1; we = 1'b0; addr = 4'd5;
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("flight rst rv_b", 72'(rv_b), 72'd0);
        chk("flight rst rv_a", 72'(rv_a), 72'd0);
        chk("flight rst rdata_a", 72'(rdata_a), 72'd0);
        chk("flight rst rdata_b", rdata_b, 72'd0);
        chk("flight rst ruser_b", 72'(ruser_b), 72'd0);
        tick();
        tick();
        rst = 1'b0;
        any_rv = 1'b0;
        repeat (4) begin
            tick();
            any_rv |= rv_a | rv_b;
        end
        chk("flight dropped", 72'(any_rv), 72'd0);
        wait_ready();
        // Contents survive reset unless the scrub wipes them
        rd_chk("post rst rd5", 4'd5, SCRUB ? 72'd0 : tbl[1].exp, SCRUB ? 4'h0 : tbl[1].uexp);

`ifdef SRAM_PIPE_INIT_SCRUB_EN
        // Interrupt scrub at address 7; it must restart from 0
        wr(4'd3, 72'h77_77777777_77777777, 9'h1FF, 4'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("restart mid busy", 72'(busy_b), 72'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy_b && n < 100) begin
            tick();
            n++;
        end
        chk("restart busy cycles", 72'(n), 72'd17);
        rd_chk("restart rd3", 4'd3, 72'd0, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_pipe.md
SRAM_PIPE -- requirements
Module: sram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning data word width in bits (any value >= 1).
REQ-002 SHALL have parameter USER_WIDTH, default 1, meaning sideband user field width.
REQ-003 SHALL have parameter USER_EN, default 0, meaning 1 stores the user field and 0 drives ruser_o to zero.
REQ-004 SHALL have parameter NUM_WORDS, default 1024, meaning memory depth in words (>= 2).
REQ-005 SHALL have parameter OUT_REGS, default 0, meaning 0 gives read latency 1 and 1 gives read latency 2.
REQ-006 SHALL have parameter SIM_INIT, default "none", meaning simulation init mode passed to the storage cuts.
REQ-007 SHALL have port clk_i, input, 1, meaning the single clock, all logic on its rising edge.
REQ-008 SHALL have port rst_i, input, 1, meaning reset, asynchronous and active-high.
REQ-009 SHALL have port req_i, input, 1, meaning access request.
REQ-010 SHALL have port we_i, input, 1, meaning 1 for write and 0 for read.
REQ-011 SHALL have port addr_i, input, $clog2(NUM_WORDS), meaning word address.
REQ-012 SHALL have port wdata_i, input, DATA_WIDTH, meaning write data.
REQ-013 SHALL have port be_i, input, (DATA_WIDTH+7)/8, meaning byte enables, bit k covering data bits [8k+7:8k].
REQ-014 SHALL have port wuser_i, input, USER_WIDTH, meaning write user field.
REQ-015 SHALL have port gnt_o, output, 1, meaning request accepted this cycle when req_i&gnt_o.
REQ-016 SHALL have port rvalid_o, output, 1, meaning a one-cycle pulse marking read data valid.
REQ-017 SHALL have port rdata_o, output, DATA_WIDTH, meaning read data.
REQ-018 SHALL have port ruser_o, output, USER_WIDTH, meaning read user field.
REQ-019 SHALL have port busy_o, output, 1, meaning the initialisation scrub is in progress.

Function
REQ-020 SHALL implement storage as ceil(DATA_WIDTH/64) 64-bit cuts, zero-padding data and byte enables above DATA_WIDTH and discarding padding on read.
REQ-021 SHALL perform at most one access per cycle (single port), accepted iff req_i&gnt_o.
REQ-022 SHALL, on an accepted write, update only the bytes with be_i set, and SHALL produce no rvalid_o.
REQ-023 SHALL, when USER_EN=1, write the whole wuser_i field on an accepted write with any be_i bit set.
REQ-024 SHALL, on an accepted read at cycle N, assert rvalid_o at cycle N+1+OUT_REGS with the data stored before cycle N.
REQ-025 SHALL accept back-to-back reads every cycle, returning them in order with no bubbles.
REQ-026 SHALL hold rdata_o/ruser_o stable from an rvalid_o pulse until the next rvalid_o.
REQ-027 SHALL return the new value when a read is accepted the cycle after a write to the same address.
REQ-028 SHALL drive ruser_o to zero when USER_EN=0.
REQ-029 SHALL drive gnt_o=!busy_o combinationally, and SHALL ignore req_i while gnt_o=0.

Reset
REQ-030 SHALL, while rst_i=1, drive rvalid_o=0, clear the read pipeline valid bits, and drive rdata_o/ruser_o=0.
REQ-031 SHALL drop a read in flight when reset is asserted, with no rvalid_o for it after reset release.
REQ-032 SHALL NOT clear memory contents on reset except through the REQ-034 scrub.

Configuration
REQ-033 SHALL gate the scrub engine with the macro SRAM_PIPE_INIT_SCRUB_EN.
REQ-034 SHALL, with SRAM_PIPE_INIT_SCRUB_EN defined, run FSM IDLE->SCRUB->DONE: leave IDLE the first cycle after rst_i deasserts, write zero data and zero user with all bytes enabled to addresses 0..NUM_WORDS-1 one per cycle with busy_o=1, and enter DONE with busy_o=0 after address NUM_WORDS-1.
REQ-035 SHALL, with SRAM_PIPE_INIT_SCRUB_EN defined, hold busy_o=1 during reset and IDLE, and restart a scrub interrupted by reset at address 0.
REQ-036 SHALL, without SRAM_PIPE_INIT_SCRUB_EN, contain no FSM, tie busy_o=0 and gnt_o=1, and leave contents per SIM_INIT.

Verification
REQ-037 SHALL cover: OUT_REGS=0, write 0xDEADBEEF_CAFEF00D @5 with be=0xFF, read @5 at cycle N -> rvalid_o=1 and rdata=0xDEADBEEF_CAFEF00D at N+1.
REQ-038 SHALL cover: OUT_REGS=1, reads @1,@2,@3 on consecutive cycles -> three consecutive rvalid_o pulses starting 2 cycles after the first read, returned in order.
REQ-039 SHALL cover: DATA_WIDTH=72, write 0xFF..FF then write 0x00 with be=0x100 -> read returns 0x00_FFFFFFFF_FFFFFFFF.
REQ-040 SHALL cover: USER_EN=1, USER_WIDTH=4, write user 0xA with be=0x01 -> read gives ruser_o=0xA; with USER_EN=0 -> ruser_o=0.
REQ-041 SHALL cover, with the macro and NUM_WORDS=16: release reset -> busy_o=1 for exactly 17 cycles (IDLE plus 16 SCRUB writes) with req_i ignored, then reading @15 gives 0.
REQ-042 SHALL cover: assert rst_i at scrub address 7 -> scrub restarts at 0 after release; assert rst_i with a read in flight -> no rvalid_o afterwards.
